// File: rtl/ifu_prefetch.sv
// Instruction fetch unit: sequential prefetch over a request/response memory bus into an in-order FIFO toward decode.
// Optional build macro IFU_MISALIGN_FAULT_EN adds out_fault and turns misaligned redirect targets into a single faulting entry.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// ST_FETCH | issue sequential requests; responses land in the FIFO
// ST_FLUSH | no issue; stale responses from before a redirect are discarded
module ifu_prefetch #(
    parameter int              XLEN      = 32,
    parameter int              BUS_W     = 64,
    parameter int              DEPTH     = 4,
    parameter int              MAX_OUTST = 2,
    parameter logic [XLEN-1:0] RESET_PC  = 32'h8000_0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_pc,
    output logic             req_valid,
    output logic [XLEN-1:0]  req_addr,
    input  logic             req_ready,
    input  logic             resp_valid,
    input  logic [BUS_W-1:0] resp_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_inst,
    output logic [XLEN-1:0]  out_pc,
`ifdef IFU_MISALIGN_FAULT_EN
    output logic             out_fault,
`endif
    output logic             busy
);

    localparam int OFF = $clog2(BUS_W / 8);
    localparam int AW  = $clog2(DEPTH);
    localparam int OW  = $clog2(MAX_OUTST + 1);
    localparam int TW  = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int CW  = $clog2(DEPTH + MAX_OUTST + 1);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(BUS_W / 8 - 1));

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic            r_run;
    logic [XLEN-1:0] r_fetch_pc;
    logic [OW-1:0]   r_outst;
    logic [OW-1:0]   r_drop;

    logic [31:0]     r_fifo_inst [DEPTH];
    logic [XLEN-1:0] r_fifo_pc   [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;

    logic [XLEN-1:0] r_tag_pc [MAX_OUTST];
    logic [TW-1:0]   r_tq_wr;
    logic [TW-1:0]   r_tq_rd;

    logic            w_accept;
    logic            w_resp_ok;
    logic            w_resp_take;
    logic            w_resp_flush;
    logic            w_push;
    logic            w_pop;
    logic [31:0]     w_push_inst;
    logic [31:0]     w_resp_inst;
    logic [XLEN-1:0] w_tag_head;
    logic [XLEN-1:0] w_redir_pc;
    logic [OW-1:0]   w_drop_redir;
    logic [CW-1:0]   w_used;
    logic            w_fault_push;
    logic            w_fault_block;

`ifdef IFU_MISALIGN_FAULT_EN
    logic r_fifo_fault [DEPTH];
    logic r_fault_mode;
    logic r_fault_pend;
    logic w_misalign;

    assign w_redir_pc    = redirect_pc;
    assign w_misalign    = (redirect_pc[1:0] != 2'b00);
    assign w_fault_push  = r_fault_pend && (r_state == ST_FETCH) && !redirect_valid;
    assign w_fault_block = r_fault_mode;
    assign w_push_inst   = w_fault_push ? 32'h0000_0013 : w_resp_inst;
    assign out_fault     = r_fifo_fault[r_rd_ptr];
`else
    assign w_redir_pc    = redirect_pc & ~(XLEN'(3));
    assign w_fault_push  = 1'b0;
    assign w_fault_block = 1'b0;
    assign w_push_inst   = w_resp_inst;
`endif

    function automatic logic [TW-1:0] tq_inc(input logic [TW-1:0] p);
        return (p == TW'(MAX_OUTST - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_tag_head = r_tag_pc[r_tq_rd];

    // Lane k of the response beat holds the word at pc; BUS_W == 32 has a single lane.
    generate
        if (BUS_W == 32) begin : g_one_lane
            assign w_resp_inst = resp_data;
        end else begin : g_lane_sel
            logic [OFF-3:0] w_k;
            assign w_k         = w_tag_head[OFF-1:2];
            assign w_resp_inst = resp_data[32*w_k +: 32];
        end
    endgenerate

    assign w_used       = CW'(r_count) + CW'(r_outst);
    assign w_accept     = req_valid && req_ready;
    // A beat with nothing outstanding is a protocol error and is ignored entirely.
    assign w_resp_ok    = resp_valid && (r_outst != '0);
    assign w_resp_take  = w_resp_ok && (r_state == ST_FETCH) && (r_drop == '0) && !redirect_valid;
    assign w_resp_flush = w_resp_ok && (r_state == ST_FLUSH) && !redirect_valid;
    assign w_drop_redir = r_outst - OW'(w_resp_ok);
    assign w_push       = w_resp_take || w_fault_push;
    assign w_pop        = out_valid && out_ready && !redirect_valid;

    assign req_addr  = r_fetch_pc & ALIGN_MASK;
    assign out_valid = (r_count != '0);
    assign out_inst  = r_fifo_inst[r_rd_ptr];
    assign out_pc    = r_fifo_pc[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        req_valid   = 1'b0;
        busy        = (r_outst != '0) || (r_state == ST_FLUSH);
        if (redirect_valid) begin
            w_state_nxt = (w_drop_redir != '0) ? ST_FLUSH : ST_FETCH;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    req_valid = r_run && !w_fault_block
                             && (r_outst < OW'(MAX_OUTST))
                             && (w_used < CW'(DEPTH));
                end
                ST_FLUSH: begin
                    if (w_resp_flush && (r_drop == OW'(1))) begin
                        w_state_nxt = ST_FETCH;
                    end
                end
                default: w_state_nxt = ST_FETCH;
            endcase
        end
    end

    // r_run holds off issue for one cycle after reset so the first cycle is quiet.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_run      <= 1'b0;
            r_fetch_pc <= RESET_PC;
            r_outst    <= '0;
            r_drop     <= '0;
        end else begin
            r_run <= 1'b1;
            if (redirect_valid) begin
                r_fetch_pc <= w_redir_pc;
                r_outst    <= w_drop_redir;
                r_drop     <= w_drop_redir;
            end else begin
                if (w_accept) begin
                    r_fetch_pc <= r_fetch_pc + XLEN'(4);
                end
                case ({w_accept, w_resp_ok})
                    2'b10:   r_outst <= r_outst + 1'b1;
                    2'b01:   r_outst <= r_outst - 1'b1;
                    default: r_outst <= r_outst;
                endcase
                if (w_resp_flush) begin
                    r_drop <= r_drop - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_tq_wr <= '0;
            r_tq_rd <= '0;
        end else if (redirect_valid) begin
            r_tq_wr <= '0;
            r_tq_rd <= '0;
        end else begin
            if (w_accept) begin
                r_tq_wr <= tq_inc(r_tq_wr);
            end
            if (w_resp_take) begin
                r_tq_rd <= tq_inc(r_tq_rd);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_tag_pc[r_tq_wr] <= r_fetch_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (redirect_valid) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // In fault mode fetch_pc never advances, so it still holds the faulting target.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_inst[r_wr_ptr] <= w_push_inst;
            r_fifo_pc[r_wr_ptr]   <= w_fault_push ? r_fetch_pc : w_tag_head;
`ifdef IFU_MISALIGN_FAULT_EN
            r_fifo_fault[r_wr_ptr] <= w_fault_push;
`endif
        end
    end

`ifdef IFU_MISALIGN_FAULT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_fault_mode <= 1'b0;
            r_fault_pend <= 1'b0;
        end else if (redirect_valid) begin
            r_fault_mode <= w_misalign;
            r_fault_pend <= w_misalign;
        end else if (w_fault_push) begin
            r_fault_pend <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_ifu_prefetch.sv
// Directed bench for ifu_prefetch: a latency-programmable memory model plus an in-order
// scoreboard that predicts every delivered {pc, inst} pair.
module tb_ifu_prefetch;

    localparam int XLEN      = 32;
    localparam int BUS_W     = 64;
    localparam int DEPTH     = 4;
    localparam int MAX_OUTST = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             redirect_valid;
    logic [XLEN-1:0]  redirect_pc;
    logic             req_valid;
    logic [XLEN-1:0]  req_addr;
    logic             req_ready;
    logic             resp_valid;
    logic [BUS_W-1:0] resp_data;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_inst;
    logic [XLEN-1:0]  out_pc;
    logic             busy;
`ifdef IFU_MISALIGN_FAULT_EN
    logic             out_fault;
`endif

    always #5 clk = ~clk;

    ifu_prefetch #(
        .XLEN(XLEN), .BUS_W(BUS_W), .DEPTH(DEPTH), .MAX_OUTST(MAX_OUTST),
        .RESET_PC(32'h8000_0000)
    ) dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_data(resp_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_pc(out_pc),
`ifdef IFU_MISALIGN_FAULT_EN
        .out_fault(out_fault),
`endif
        .busy(busy)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return {pc[15:0], pc[31:16]} ^ 32'hC0DE_5A5A;
    endfunction

    // memory model and scoreboard state
    logic [31:0] mq_addr [16];
    int          mq_due  [16];
    int          mq_head = 0;
    int          mq_tail = 0;
    int          mq_n    = 0;
    int          mem_lat = 1;
    bit          mem_hold = 1'b0;
    int          cyc = 0;
    logic [31:0] acc_addr [256];
    int          n_acc = 0;
    int          n_pop = 0;
    int          max_occ = 0;
    int          first_acc_cyc = -1;
    int          first_out_cyc = -1;
    logic [31:0] exp_pc = 32'h8000_0000;
    bit          want_first = 1'b0;
    logic [31:0] first_pc = 32'h0;
    int          n_zero = 0;

    initial begin
        resp_valid = 1'b0;
        resp_data  = '0;
        forever begin
            @(negedge clk);
            cyc++;
            resp_valid = 1'b0;
            resp_data  = '0;
            if (!mem_hold && mq_n > 0 && mq_due[mq_head] <= cyc) begin
                resp_valid = 1'b1;
                resp_data  = {inst_of(mq_addr[mq_head] + 32'd4), inst_of(mq_addr[mq_head])};
                mq_head    = (mq_head + 1) % 16;
                mq_n--;
            end
            if (req_valid && req_ready) begin
                if (first_acc_cyc < 0) first_acc_cyc = cyc;
                if (n_acc < 256) acc_addr[n_acc] = req_addr;
                n_acc++;
                mq_addr[mq_tail] = req_addr;
                mq_due[mq_tail]  = cyc + mem_lat;
                mq_tail = (mq_tail + 1) % 16;
                mq_n++;
            end
            if (redirect_valid) begin
                exp_pc     = {redirect_pc[31:2], 2'b00};
                want_first = 1'b1;
            end else if (out_valid && out_ready) begin
                if (first_out_cyc < 0) first_out_cyc = cyc;
                chk_val("out_pc", out_pc, exp_pc);
                chk_val("out_inst", out_inst, inst_of(exp_pc));
                if (want_first) begin
                    first_pc   = out_pc;
                    want_first = 1'b0;
                end
                if (out_pc == 32'h0) n_zero++;
                exp_pc = exp_pc + 32'd4;
                n_pop++;
            end
            if (n_acc - n_pop > max_occ) max_occ = n_acc - n_pop;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    int k;
    int p;

    initial begin
        rst            = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        req_ready      = 1'b1;
        out_ready      = 1'b1;

        // reset values
        mid();
        chk_val("rst_req_valid", req_valid, 1'b0);
        chk_val("rst_out_valid", out_valid, 1'b0);
        chk_val("rst_busy", busy, 1'b0);
        chk_val("rst_req_addr", req_addr, 32'h8000_0000);
        step(1);
        rst = 1'b1;
        mid();
        chk_val("post_rst_req_valid", req_valid, 1'b0);
        chk_val("post_rst_busy", busy, 1'b0);

        // sequential fetch, 1-cycle memory
        step(14);
        chk_val("acc0", acc_addr[0], 32'h8000_0000);
        chk_val("acc1", acc_addr[1], 32'h8000_0000);
        chk_val("acc2", acc_addr[2], 32'h8000_0008);
        chk_val("latency", first_out_cyc - first_acc_cyc, 2);

        // decode stall: credit limit and ordering
        step(1);
        out_ready = 1'b0;
        step(20);
        mid();
        chk_val("full_req_valid", req_valid, 1'b0);
        chk_val("full_out_valid", out_valid, 1'b1);
        chk_val("full_occ", n_acc - n_pop, 4);
        chk_val("max_occ", max_occ, 4);
        step(1);
        out_ready = 1'b1;
        step(20);

        // redirect with two stale requests in flight
        mem_lat  = 3;
        mem_hold = 1'b1;
        step(8);
        mid();
        chk_val("outst_full_busy", busy, 1'b1);
        chk_val("outst_full_req", req_valid, 1'b0);
        step(1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0100;
        step(1);
        redirect_valid = 1'b0;
        mem_hold       = 1'b0;
        mid();
        chk_val("flush_busy0", busy, 1'b1);
        chk_val("flush_out_valid", out_valid, 1'b0);
        chk_val("flush_req0", req_valid, 1'b0);
        step(1);
        mid();
        chk_val("flush_busy1", busy, 1'b1);
        chk_val("flush_req1", req_valid, 1'b0);
        step(1);
        mid();
        chk_val("flush_done_busy", busy, 1'b0);
        chk_val("flush_done_req", req_valid, 1'b1);
        chk_val("flush_done_addr", req_addr, 32'h8000_0100);
        step(20);
        chk_val("first_pc_redir", first_pc, 32'h8000_0100);

        // redirect coinciding with the only response and out_ready
        req_ready = 1'b0;
        step(10);
        mem_lat   = 1;
        mem_hold  = 1'b1;
        req_ready = 1'b1;
        step(1);
        req_ready = 1'b0;
        step(1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0200;
        mem_hold       = 1'b0;
        out_ready      = 1'b1;
        mid();
        p = n_pop;
        step(1);
        redirect_valid = 1'b0;
        req_ready      = 1'b1;
        mid();
        chk_val("same_cyc_busy", busy, 1'b0);
        chk_val("same_cyc_out_valid", out_valid, 1'b0);
        chk_val("same_cyc_req", req_valid, 1'b1);
        chk_val("same_cyc_addr", req_addr, 32'h8000_0200);
        chk_val("same_cyc_no_deliver", n_pop, p);
        step(10);

        // address wrap at the top of the space
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        mid();
        k = n_acc;
        step(1);
        redirect_valid = 1'b0;
        step(15);
        if (k + 1 < 256) begin
            chk_val("wrap_acc0", acc_addr[k], 32'hFFFF_FFF8);
            chk_val("wrap_acc1", acc_addr[k+1], 32'h0000_0000);
        end else begin
            chk_val("wrap_index", k, 0);
        end
        chk_val("wrap_pc0_seen", n_zero != 0, 1'b1);
        chk_val("pops_seen", n_pop > 20, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ifu_prefetch.md
Name: ifu_prefetch

Overview:
- Parametrised instruction fetch unit with an explicit request/response bus to instruction memory and an in-order prefetch FIFO toward decode.
- Generates sequential fetch addresses and keeps up to MAX_OUTST requests in flight.
- Selects the 32-bit instruction from each BUS_W-bit response.
- Handles redirects (branch/trap) by flushing buffered entries and discarding stale in-flight responses.

Parameters:
- XLEN, 32, PC/address width.
- BUS_W, 64, response data width; power of two, 32 to 256.
- DEPTH, 4, FIFO entries; power of two, 2 or more.
- MAX_OUTST, 2, maximum outstanding requests; 1 to DEPTH.
- RESET_PC, 32'h8000_0000, first fetch PC after reset.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- redirect_valid  in  1  redirect request; has priority over everything else
- redirect_pc  in  XLEN  redirect target
- req_valid  out  1  fetch request valid
- req_addr  out  XLEN  request address, aligned to BUS_W/8 bytes
- req_ready  in  1  memory accepts request
- resp_valid  in  1  response beat; one per accepted request, in order
- resp_data  in  BUS_W  response data
- out_valid  out  1  instruction available
- out_ready  in  1  decode accepts instruction
- out_inst  out  32  instruction
- out_pc  out  XLEN  PC of out_inst
- busy  out  1  outstanding requests nonzero, or state is FLUSH

Behaviour:
- Reset (rst==0 at posedge):
  - fetch_pc=RESET_PC; FIFO empty; outst=0; drop=0; state=FETCH.
  - req_valid=0, out_valid=0, busy=0 in the cycle after reset.
- req_addr = fetch_pc with its low log2(BUS_W/8) bits cleared.
- Request issue rule: req_valid=1 only when all hold:
  - state==FETCH, redirect_valid==0
  - outst<MAX_OUTST
  - fifo_count+outst<DEPTH (credit rule: every response always has a free slot)
- Request accept: handshake = req_valid&&req_ready.
  - fetch_pc <= fetch_pc+4 (wraps modulo 2^XLEN).
  - The request's PC is pushed into a tag queue (MAX_OUTST deep).
- Response (state FETCH, drop==0):
  - Pops the tag queue.
  - Pushes {inst, pc} into the FIFO. inst = resp_data[32*k +: 32], k = pc[log2(BUS_W/8)-1:2].
- Outstanding count:
  - outst +1 on accept, -1 on resp_valid; simultaneous accept and response leaves outst unchanged.
  - resp_valid while outst==0 is a protocol error: ignored, no state change.
- Output:
  - out_valid = FIFO not empty; out_inst/out_pc = FIFO head, driven from registers.
  - Pop on out_valid&&out_ready.
  - Push and pop in the same cycle are both legal, including on a full or empty FIFO.
- Latency: accept at cycle N, resp_valid at cycle M ⇒ out_valid at M+1.
- Redirect (redirect_valid==1 at posedge), any state:
  - FIFO cleared; fetch_pc <= redirect_pc; tag queue cleared.
  - drop <= outst minus 1 if resp_valid is high that same cycle (that response is discarded).
  - Any request accepted that cycle is impossible, since req_valid is forced to 0.
  - state <= FLUSH if the resulting drop>0, else FETCH.
  - out_valid=0 in the next cycle; out_ready in the redirect cycle pops nothing.
- FSM:
  - FETCH: normal issue.
  - FLUSH: no issue; each resp_valid decrements drop and outst, data discarded; drop reaching 0 ⇒ FETCH next cycle.
  - A new redirect in FLUSH recomputes drop and keeps the latest target.
- Reset mid-operation (rst low): all of the above state returns to reset values. Responses to pre-reset requests arriving after reset are ignored via the outst==0 rule; the environment must not deliver them.

Optional Feature:
- Macro: IFU_MISALIGN_FAULT_EN.
- Enabled:
  - Adds port out_fault (out, 1), stored per FIFO entry.
  - A redirect_pc with bits[1:0]!=0 sets fault mode: no memory requests issue.
  - One entry is pushed {inst=32'h0000_0013, pc=redirect_pc, fault=1}; state then holds in FETCH with no issue until the next redirect.
- Disabled:
  - No out_fault port.
  - redirect_pc[1:0] are forced to 0 before use.

Test Plan:
- Reset, BUS_W=64, memory with 1-cycle response, out_ready=1 → req_addr 8000_0000, 8000_0000, 8000_0008; out_pc sequence 8000_0000, 8000_0004, 8000_0008; out_inst alternates low/high halves.
- out_ready=0 for 20 cycles, DEPTH=4 → fifo_count+outst never exceeds 4; req_valid low when full; no response lost; order preserved after release.
- Redirect to 8000_0100 with 2 outstanding, responses delayed 3 cycles → state FLUSH, both stale responses dropped; first out_pc = 8000_0100; busy high until drop==0.
- Redirect in the same cycle as resp_valid and out_ready with outst=1 → drop=0, state FETCH, nothing delivered; next request at 8000_0200 (the target).
- fetch_pc=FFFF_FFFC, XLEN=32 → next request address 0000_0000, out_pc wraps to 0.
- IFU_MISALIGN_FAULT_EN, redirect to 8000_0102 → no req_valid; one entry out_fault=1, out_pc=8000_0102, out_inst=0000_0013.
